// File: rtl/ee354_gcd_pkg.sv
// Shared types and constants for the ee354 binary (Stein) GCD responder.
// State codes double as the one-hot q_* flags.
package ee354_gcd_pkg;

    localparam int GCD_WIDTH = 8;
    localparam int CYC_W     = 16;
    localparam int CNT_W     = 8;

    typedef enum logic [3:0] {
        QI    = 4'b1000,
        QSUB  = 4'b0100,
        QMULT = 4'b0010,
        QDONE = 4'b0001
    } state_e;

endpackage

// File: rtl/ee354_gcd_step.sv
// Combinational Stein step: one shift/compare/subtract action on (a, b, cnt).
// done=1 means the odd part of the GCD is available on result.
module ee354_gcd_step
    import ee354_gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Priority-ordered rule selection; earlier rules win.
    always_comb begin
        a_nxt   = a;
        b_nxt   = b;
        cnt_nxt = cnt;
        done    = 1'b0;
        result  = {WIDTH{1'b0}};
        if (a == {WIDTH{1'b0}}) begin
            done   = 1'b1;
            result = b;
        end else if (b == {WIDTH{1'b0}}) begin
            done   = 1'b1;
            result = a;
        end else if (a == b) begin
            done   = 1'b1;
            result = a;
        end else if (!a[0] && !b[0]) begin
            a_nxt   = a >> 1;
            b_nxt   = b >> 1;
            cnt_nxt = cnt + 8'd1;
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a > b) begin
            a_nxt = a - b;
        end else begin
            b_nxt = b - a;
        end
    end

endmodule

// File: rtl/ee354_gcd_stein.sv
// Stein GCD responder with Start/Ack handshake and one-hot q_* state flags.
// Optional GCD_CYCLE_COUNT_EN adds a saturating Cycles count of q_Sub/q_Mult cycles.
module ee354_gcd_stein
    import ee354_gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [7:0]       i_count,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0] Cycles
`endif
);

    state_e           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] ab_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             step_done_s;
    logic [WIDTH-1:0] step_res_s;

    ee354_gcd_step #(.WIDTH(WIDTH)) u_step (
        .a       (a_r),
        .b       (b_r),
        .cnt     (cnt_r),
        .a_nxt   (a_nxt_s),
        .b_nxt   (b_nxt_s),
        .cnt_nxt (cnt_nxt_s),
        .done    (step_done_s),
        .result  (step_res_s)
    );

    // Handshake FSM with working, result and power-of-two count registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= QI;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            ab_r    <= {WIDTH{1'b0}};
            cnt_r   <= 8'd0;
        end else if (CEN) begin
            case (state_r)
                QI: begin
                    if (Start) begin
                        a_r     <= Ain;
                        b_r     <= Bin;
                        ab_r    <= {WIDTH{1'b0}};
                        cnt_r   <= 8'd0;
                        state_r <= QSUB;
                    end
                end
                QSUB: begin
                    if (step_done_s) begin
                        ab_r    <= step_res_s;
                        state_r <= QMULT;
                    end else begin
                        a_r   <= a_nxt_s;
                        b_r   <= b_nxt_s;
                        cnt_r <= cnt_nxt_s;
                    end
                end
                QMULT: begin
                    // Result never exceeds max(Ain,Bin), so the shift cannot overflow.
                    if (cnt_r == 8'd0) begin
                        state_r <= QDONE;
                    end else begin
                        ab_r  <= ab_r << 1;
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                QDONE: begin
                    if (Ack) begin
                        state_r <= QI;
                    end
                end
                default: begin
                    state_r <= QI;
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_r;

    // Saturating count of busy (q_Sub/q_Mult) cycles for the current operation.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_r <= 16'd0;
        end else if (CEN) begin
            if (state_r == QI && Start) begin
                cyc_r <= 16'd0;
            end else if ((state_r == QSUB || state_r == QMULT) && cyc_r != 16'hFFFF) begin
                cyc_r <= cyc_r + 16'd1;
            end
        end
    end

    assign Cycles = cyc_r;
`endif

    assign A       = a_r;
    assign B       = b_r;
    assign AB_GCD  = ab_r;
    assign i_count = cnt_r;
    assign q_I     = state_r[3];
    assign q_Sub   = state_r[2];
    assign q_Mult  = state_r[1];
    assign q_Done  = state_r[0];

endmodule

// File: tb/tb_ee354_gcd_stein.sv
// Directed self-checking bench for ee354_gcd_stein (Euclid reference model).
// Define GCD_CYCLE_COUNT_EN to also check the Cycles port.
module tb_ee354_gcd_stein;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       CEN;
    logic       Start;
    logic       Ack;
    logic [7:0] Ain;
    logic [7:0] Bin;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] AB_GCD;
    logic [7:0] i_count;
    logic       q_I;
    logic       q_Sub;
    logic       q_Mult;
    logic       q_Done;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] Cycles;
`endif

    int total = 0;
    int bad   = 0;

    ee354_gcd_stein #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .CEN     (CEN),
        .Start   (Start),
        .Ack     (Ack),
        .Ain     (Ain),
        .Bin     (Bin),
        .A       (A),
        .B       (B),
        .AB_GCD  (AB_GCD),
        .i_count (i_count),
        .q_I     (q_I),
        .q_Sub   (q_Sub),
        .q_Mult  (q_Mult),
        .q_Done  (q_Done)
`ifdef GCD_CYCLE_COUNT_EN
        ,
        .Cycles  (Cycles)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input int ain, input int bin);
        Ain   = ain[7:0];
        Bin   = bin[7:0];
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Ain   = 8'hA5;
        Bin   = 8'h5A;
    endtask

    task automatic run_to_done(output int nsub, output int nmult, output int peak, output int ab_mult);
        nsub = 0; nmult = 0; peak = 0; ab_mult = -1;
        while (q_Sub && nsub < 100) begin
            if (int'(i_count) > peak) peak = int'(i_count);
            tick();
            nsub++;
        end
        ab_mult = int'(AB_GCD);
        while (q_Mult && nmult < 100) begin
            tick();
            nmult++;
        end
        check("reach_done", {31'd0, q_Done}, 32'd1);
    endtask

    task automatic ack_op(input bit with_start);
        Ack   = 1'b1;
        Start = with_start;
        tick();
        Ack   = 1'b0;
        Start = 1'b0;
        check("ack_to_idle", {31'd0, q_I}, 32'd1);
    endtask

    initial begin
        int ns, nm, pk, abm, exp_v, n;
        logic [7:0] sa, sb, sk;
        Reset_n = 1'b0; CEN = 1'b1; Start = 1'b0; Ack = 1'b0; Ain = 8'd0; Bin = 8'd0;
        #12;
        check("rst_qI", {31'd0, q_I}, 32'd1);
        check("rst_flags", {29'd0, q_Sub, q_Mult, q_Done}, 32'd0);
        check("rst_regs", {A, B, AB_GCD, i_count}, 32'd0);
        Reset_n = 1'b1;
        tick();

        // 36,24: 6 q_Sub, 3 q_Mult, result 12
        start_op(36, 24);
        check("s1_in_sub", {31'd0, q_Sub}, 32'd1);
        run_to_done(ns, nm, pk, abm);
        check("s1_nsub", ns, 32'd6);
        check("s1_nmult", nm, 32'd3);
        check("s1_gcd", {24'd0, AB_GCD}, 32'd12);
        check("s1_icount", {24'd0, i_count}, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check("s1_cycles", {16'd0, Cycles}, 32'd9);
`endif
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("done_hold", {31'd0, q_Done}, 32'd1);
        check("done_hold_gcd", {24'd0, AB_GCD}, 32'd12);
        ack_op(1'b0);
        tick();
        check("idle_keeps_gcd", {24'd0, AB_GCD}, 32'd12);

        // 64,48: k peaks at 4, odd part 1, final 16; Ack wins over Start
        start_op(64, 48);
        run_to_done(ns, nm, pk, abm);
        check("s2_peak_k", pk, 32'd4);
        check("s2_ab_mult", abm, 32'd1);
        check("s2_gcd", {24'd0, AB_GCD}, 32'd16);
        ack_op(1'b1);
        check("s2_no_restart", {31'd0, q_Sub}, 32'd0);

        start_op(17, 17);
        run_to_done(ns, nm, pk, abm);
        check("s3_nsub", ns, 32'd1);
        check("s3_nmult", nm, 32'd1);
        check("s3_gcd", {24'd0, AB_GCD}, 32'd17);
        ack_op(1'b0);

        start_op(0, 45);
        run_to_done(ns, nm, pk, abm);
        check("s4_gcd", {24'd0, AB_GCD}, 32'd45);
        ack_op(1'b0);

        start_op(0, 0);
        run_to_done(ns, nm, pk, abm);
        check("s5_gcd", {24'd0, AB_GCD}, 32'd0);
        ack_op(1'b0);

        // CEN stall in the middle of q_Sub
        start_op(36, 24);
        tick();
        tick();
        CEN = 1'b0;
        sa = A; sb = B; sk = i_count;
        for (int i = 0; i < 5; i++) begin
            Start = 1'b1; Ack = 1'b1;
            tick();
            check("stall_ab", {16'd0, A, B}, {16'd0, sa, sb});
            check("stall_k", {24'd0, i_count}, {24'd0, sk});
            check("stall_state", {28'd0, q_I, q_Sub, q_Mult, q_Done}, 32'd4);
        end
        Start = 1'b0; Ack = 1'b0; CEN = 1'b1;
        run_to_done(ns, nm, pk, abm);
        check("stall_gcd", {24'd0, AB_GCD}, 32'd12);
        ack_op(1'b0);

        // Asynchronous reset between clock edges during q_Mult
        start_op(36, 24);
        n = 0;
        while (!q_Mult && n < 50) begin
            tick();
            n++;
        end
        check("reach_mult", {31'd0, q_Mult}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_qI", {28'd0, q_I, q_Sub, q_Mult, q_Done}, 32'd8);
        check("arst_regs", {A, B, AB_GCD, i_count}, 32'd0);
`ifdef GCD_CYCLE_COUNT_EN
        check("arst_cycles", {16'd0, Cycles}, 32'd0);
`endif
        #3;
        Reset_n = 1'b1;
        tick();

        // Sweep against the Euclid model
        for (int a = 2; a <= 63; a++) begin
            for (int b = 2; b <= 63; b += 7) begin
                start_op(a, b);
                run_to_done(ns, nm, pk, abm);
                exp_v = ref_gcd(a, b);
                check($sformatf("sweep_%0d_%0d", a, b), {24'd0, AB_GCD}, exp_v);
                check("sweep_bound", (ns <= 18) ? 32'd1 : 32'd0, 32'd1);
                ack_op(1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
